// File: rtl/cpu_defs.sv
// ----------------------------------------------------------------------------
// cpu_defs : shared constants and types for the instruction-fetch front end.
// Holds the default reset PC, the NOP encoding used to clear IF/ID, and the
// fetch FSM state encodings.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_defs;

  // First fetch address after reset unless overridden on the instance.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Instruction word driven into IF/ID while it holds no instruction.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Fetch FSM: S_REQ issues a request, S_FULL waits for the skid to drain.
  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_FULL = 1'b1
  } fetch_state_e;

  // Branch/jump targets are word aligned; low two bits are discarded.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return target & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ----------------------------------------------------------------------------
// fetch_skid_buf : one-entry holding register for a fetched instruction that
// arrived while IF/ID was occupied and stalled.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_skid_buf
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Capture on load, release on unload; load wins if both are ever asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
      pc_q    <= 32'h0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit : instruction fetch stage. Keeps the fetch PC, issues one
// instruction-memory request at a time, and delivers {instr, pc, pc+8} into
// the IF/ID register with a one-entry skid buffer to absorb ID stalls.
// Redirects never cancel the fetch in flight (delay-slot semantics); a
// redirect that arrives without a completing fetch is kept as pending.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pc_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         pend_valid_q;
  logic [31:0]  pend_pc_q;
  logic         if_id_valid_q;
  logic [31:0]  if_id_instr_q;
  logic [31:0]  if_id_pc_q;
  logic [31:0]  if_id_pc8_q;

  logic [31:0]  redirect_tgt_d;
  logic         fetch_done_d;
  logic         load_skid_d;
  logic         load_ifid_d;
  logic         drain_skid_d;
  logic [31:0]  pc_d;

  logic         skid_valid;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;

  // Decode this cycle's fetch completion, where it lands, and the next PC.
  always_comb begin
    redirect_tgt_d = align_target(redirect_pc);
    fetch_done_d   = (state_q == S_REQ) && imem_ack;
    load_skid_d    = fetch_done_d && if_id_valid_q && stall;
    load_ifid_d    = fetch_done_d && !load_skid_d;
    drain_skid_d   = (state_q == S_FULL) && !stall;
    if (redirect_valid) begin
      pc_d = redirect_tgt_d;
    end else if (pend_valid_q) begin
      pc_d = pend_pc_q;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Fetch FSM plus PC, pending-redirect and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= 32'h0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_WORD;
      if_id_pc_q    <= 32'h0;
      if_id_pc8_q   <= 32'h0;
    end else begin
      case (state_q)
        S_REQ:   if (load_skid_d) state_q <= S_FULL;
        S_FULL:  if (!stall) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase

      if (fetch_done_d) begin
        pc_q <= pc_d;
      end

      // A completed fetch consumes any redirect; otherwise the latest wins.
      if (fetch_done_d) begin
        pend_valid_q <= 1'b0;
      end else if (redirect_valid) begin
        pend_valid_q <= 1'b1;
        pend_pc_q    <= redirect_tgt_d;
      end

      if (load_ifid_d) begin
        if_id_valid_q <= 1'b1;
        if_id_instr_q <= imem_rdata;
        if_id_pc_q    <= pc_q;
        if_id_pc8_q   <= pc_q + 32'd8;
      end else if (drain_skid_d) begin
        if_id_valid_q <= skid_valid;
        if_id_instr_q <= skid_instr;
        if_id_pc_q    <= skid_pc;
        if_id_pc8_q   <= skid_pc + 32'd8;
      end else if (!stall) begin
        if_id_valid_q <= 1'b0;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_skid_d),
    .unload_i (drain_skid_d),
    .instr_i  (imem_rdata),
    .pc_i     (pc_q),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc8   = if_id_pc8_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit : scoreboard bench for pc_fetch_unit. Every accepted fetch
// pushes {instr, pc, pc+8}; the head is compared against IF/ID while valid
// and popped when ID consumes it. The fetch PC is predicted independently.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_unit;
  import cpu_defs::*;

  localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc8;

  pc_fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc8      (if_id_pc8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
  } ifid_t;

  ifid_t       sb_q[$];
  logic [31:0] m_pc;
  logic        m_pend_v;
  logic [31:0] m_pend;
  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned tag_ctr = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all visible outputs with the model; called away from the clock edge.
  task automatic check_outputs();
    logic       exp_req;
    ifid_t      head;
    exp_req = (sb_q.size() < 2);
    check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("pc", pc, m_pc);
    check_eq("if_id_valid", {31'b0, if_id_valid}, {31'b0, (sb_q.size() > 0)});
    if (sb_q.size() > 0) begin
      head = sb_q[0];
      check_eq("if_id_instr", if_id_instr, head.instr);
      check_eq("if_id_pc", if_id_pc, head.pc);
      check_eq("if_id_pc8", if_id_pc8, head.pc8);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge.
  task automatic step(input logic ack, input logic stl, input logic rv, input logic [31:0] rpc);
    logic        accept;
    logic        consume;
    logic [31:0] rdata;
    rdata          = 32'hC0DE_0000 + tag_ctr;
    tag_ctr++;
    imem_ack       = ack;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdata     = rdata;
    accept  = ack && (sb_q.size() < 2);
    consume = (sb_q.size() > 0) && !stl;
    if (consume) void'(sb_q.pop_front());
    if (accept) begin
      sb_q.push_back('{instr: rdata, pc: m_pc, pc8: m_pc + 32'd8});
      if (rv)            m_pc = {rpc[31:2], 2'b00};
      else if (m_pend_v) m_pc = m_pend;
      else               m_pc = m_pc + 32'd4;
      m_pend_v = 1'b0;
    end else if (rv) begin
      m_pend_v = 1'b1;
      m_pend   = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Assert reset asynchronously, check the reset image, then release.
  task automatic do_reset();
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rdata     = 32'h0;
    #1;
    check_eq("rst_if_id_valid", {31'b0, if_id_valid}, 32'h0);
    check_eq("rst_if_id_instr", if_id_instr, 32'h0);
    check_eq("rst_if_id_pc", if_id_pc, 32'h0);
    check_eq("rst_if_id_pc8", if_id_pc8, 32'h0);
    check_eq("rst_pc", pc, C_RESET_PC);
    check_eq("rst_imem_req", {31'b0, imem_req}, 32'h1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    m_pc     = C_RESET_PC;
    m_pend_v = 1'b0;
    m_pend   = 32'h0;
    check_outputs();
    check_eq("post_rst_addr", imem_addr, C_RESET_PC);
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    @(negedge clk);
    do_reset();

    // Back-to-back fetches; redirect to 0x3024 while 0x3008 is acked.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_3024);
    check_eq("redir_addr", imem_addr, 32'h0000_3024);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Two redirects while ack is low: latest one is fetched after the ack.
    step(1'b0, 1'b0, 1'b1, 32'h0000_3100);
    step(1'b0, 1'b0, 1'b1, 32'h0000_3200);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("latest_wins", imem_addr, 32'h0000_3200);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Four stalled cycles with ack held high, then release.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect arriving while the skid buffer is full becomes pending.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_4001);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Reset taken while in S_FULL, then a target near the top of memory.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    do_reset();
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    check_eq("wrap_target", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("wrap_zero", imem_addr, 32'h0000_0000);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Reset with a fetch outstanding, then a 3-cycle ack delay at 0x3000.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Random traffic: ack, stall and occasional redirects.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 5) == 0), $urandom);
    end

    // Drain whatever remains.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-003 SHALL have port stall  in  1  ID stage not accepting; IF/ID contents are held.
REQ-004 SHALL have port redirect_valid  in  1  one-cycle pulse carrying a resolved branch/jump next-PC.
REQ-005 SHALL have port redirect_pc  in  32  branch/jump target; bits [1:0] ignored.
REQ-006 SHALL have port imem_req  out  1  instruction-memory request.
REQ-007 SHALL have port imem_addr  out  32  fetch address (= pc).
REQ-008 SHALL have port imem_ack  in  1  read data valid this cycle; meaningful only while imem_req=1.
REQ-009 SHALL have port imem_rdata  in  32  instruction word.
REQ-010 SHALL have port pc  out  32  current fetch PC, for the next-PC logic.
REQ-011 SHALL have ports if_id_valid  out  1, if_id_instr  out  32, if_id_pc  out  32, if_id_pc8  out  32 (= if_id_pc+8, link address).

Function
REQ-012 SHALL implement two states: S_REQ (imem_req=1, imem_addr=pc) and S_FULL (imem_req=0, skid buffer occupied).
REQ-013 In S_REQ, on imem_ack with (if_id_valid=0 or stall=0): SHALL load IF/ID with {imem_rdata, pc}, set if_id_valid=1, advance pc, stay in S_REQ.
REQ-014 In S_REQ, on imem_ack with if_id_valid=1 and stall=1: SHALL load skid buffer with {imem_rdata, pc}, advance pc, go to S_FULL.
REQ-015 In S_FULL with stall=0: SHALL move skid buffer into IF/ID (if_id_valid=1) and return to S_REQ; with stall=1, SHALL hold everything.
REQ-016 With no load into IF/ID and stall=0, SHALL clear if_id_valid; with stall=1, SHALL hold all IF/ID outputs.
REQ-017 Next-PC on a completed fetch SHALL be: redirect_pc if redirect_valid is high that cycle; else pending target if one is stored; else pc+4.
REQ-018 A redirect_valid pulse not coinciding with a completed fetch SHALL be stored as pending; pending SHALL clear when used.
REQ-019 A later redirect_valid while a target is pending SHALL overwrite it (latest wins).
REQ-020 Redirect SHALL never abort the fetch in flight; that instruction is the delay slot and SHALL reach IF/ID.
REQ-021 Targets SHALL have bits [1:0] forced to 00; pc+4 and pc+8 SHALL wrap modulo 2^32.
REQ-022 pc SHALL change only on a completed fetch; imem_addr SHALL stay stable while imem_req=1 and ack is low.
REQ-023 Fetch latency SHALL be zero added cycles: ack in cycle N places the instruction in IF/ID at edge N+1 (if not stalled).

Reset
REQ-024 While rst_n=0: pc=RESET_PC, state=S_REQ, if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc8=0, skid empty, pending cleared.
REQ-025 Reset asserted mid-fetch SHALL discard the outstanding access; imem_req=1 with imem_addr=RESET_PC on the first cycle after release.

Structure
REQ-026 RESET_PC, NOP word 32'h0 and state encodings SHALL live in shared package cpu_defs.
REQ-027 Skid buffer SHALL be one sub-module, fetch_skid_buf (1-entry valid/data/pc register).

Verification
REQ-028 Reset release, imem_ack every cycle, stall=0 -> IF/ID pcs 0x3000, 0x3004, 0x3008 on consecutive cycles; if_id_pc8=0x3008 for first.
REQ-029 imem_ack delayed 3 cycles at 0x3000 -> imem_addr held 0x3000, pc unchanged, if_id_valid=0 until edge after ack.
REQ-030 redirect_valid=1, redirect_pc=0x3024 during fetch of 0x3008 (acked same cycle) -> 0x3008 enters IF/ID, next fetch 0x3024.
REQ-031 redirect 0x3100 then 0x3200 while ack low -> next fetch after current ack is 0x3200.
REQ-032 stall=1 for 4 cycles with ack always 1 -> one skid load, imem_req=0 in S_FULL, no instruction lost or duplicated after release.
REQ-033 rst_n low during S_FULL -> if_id_valid=0, pc=0x3000, skid/pending cleared; redirect_pc=0xFFFF_FFFE -> fetch 0xFFFF_FFFC, then 0x0000_0000.
